ma_dm_arbiter: RTL and testbench
================================

MA_DM_ARBITER -- requirements
Module: ma_dm_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6, number of datamover requesters: 0-3 mrf0..mrf3, 4 vrf_ldr, 5 vrf_str.
REQ-002 Parameter DDR4_ADDRWIDTH, default 36, DDR4 byte address width.
REQ-003 Parameter BRAM_ADDRWIDTH, default 10, register-file row address width (MRF requesters zero-extend their 6-bit address).
REQ-004 Parameter BTT_WIDTH, default 15, bytes-to-transfer width.
REQ-005 Parameter TIMEOUT_CYCLES, default 4096, status watchdog limit (>=2).
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 ddr4_linkup_i  input  1  DDR4 ready; no new grants while low.
REQ-009 req_valid_i  input  NUM_REQ  per-requester command valid.
REQ-010 req_ready_o  output  NUM_REQ  per-requester command accept.
REQ-011 req_write_i  input  NUM_REQ  1 = register file to DDR4, 0 = DDR4 to register file.
REQ-012 req_addr_i  input  NUM_REQ*DDR4_ADDRWIDTH  packed DDR4 addresses; requester i at slice i.
REQ-013 req_bram_addr_i  input  NUM_REQ*BRAM_ADDRWIDTH  packed register-file addresses.
REQ-014 req_btt_i  input  NUM_REQ*BTT_WIDTH  packed byte counts.
REQ-015 done_o / err_o  output  NUM_REQ each  one-cycle completion pulse / failure flag valid with done.
REQ-016 cmd_valid_o, cmd_ready_i  out/in  1 each  datamover command handshake.
REQ-017 cmd_write_o, cmd_addr_o, cmd_bram_addr_o, cmd_btt_o  output  1/DDR4_ADDRWIDTH/BRAM_ADDRWIDTH/BTT_WIDTH  latched command.
REQ-018 sts_valid_i, sts_ok_i, sts_ready_o  in/in/out  1 each  datamover status handshake.
REQ-019 busy_o, stray_sts_o  output  1 each  transaction in flight / sticky unexpected-status flag.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT_STS; exactly one transaction outstanding at any time.
REQ-021 In IDLE with ddr4_linkup_i=1: winner = first requester with req_valid_i set, searching from rr_ptr upward modulo NUM_REQ; req_ready_o[winner]=1 combinationally that cycle; all other req_ready_o bits 0.
REQ-022 On accept: latch winner's write/addr/bram_addr/btt and grant index; rr_ptr <= (winner+1) mod NUM_REQ; next state ISSUE.
REQ-023 ISSUE: cmd_valid_o=1 with stable latched fields until cmd_ready_i=1; then WAIT_STS and clear the watchdog counter.
REQ-024 WAIT_STS: sts_ready_o=1; on sts_valid_i=1, next cycle done_o[grant]=1 and err_o[grant]=~sts_ok_i; state -> IDLE.
REQ-025 Watchdog increments each WAIT_STS cycle without status; at TIMEOUT_CYCLES-1 with no status: done_o[grant]=1, err_o[grant]=1 next cycle; state -> IDLE.
REQ-026 sts_ready_o=1 also in IDLE; a status accepted in IDLE (late or spurious) is discarded and sets stray_sts_o until reset.
REQ-027 IDLE may grant a new requester in the same cycle done_o pulses (1-cycle turnaround).
REQ-028 ddr4_linkup_i falling while not IDLE does not abort; the transaction completes, then no grant until linkup returns.
REQ-029 busy_o=1 in ISSUE and WAIT_STS, 0 in IDLE.
REQ-030 req_btt_i=0 is forwarded unchanged; the arbiter does no length checking.
REQ-031 Request changes while not granted are ignored; the requester holds valid until ready.

Reset
REQ-032 rst=1 forces IDLE asynchronously: rr_ptr=0, watchdog=0, stray_sts_o=0, all done_o/err_o/cmd_valid_o/busy_o=0, latched fields=0.
REQ-033 Reset mid-transaction drops it with no done_o pulse; sts_ready_o=1 after release (IDLE).

Verification
REQ-034 After reset, linkup=1, req_valid_i=6'b111111, cmd_ready_i=1, status ok after 3 cycles each -> grant order 0,1,2,3,4,5,0; every done_o pulse has err_o=0.
REQ-035 Requester 4 addr=0x1_0000_0040, bram=0x3FF, btt=128, write=1 -> cmd_* fields exact, cmd_valid_o held over 5 cycles of cmd_ready_i=0, single accept.
REQ-036 Status with sts_ok_i=0 for requester 2 -> done_o[2]=1 and err_o[2]=1 for one cycle the cycle after the status handshake.
REQ-037 TIMEOUT_CYCLES=8, no status -> done_o/err_o pulse on grant 8 cycles after cmd accept; status arriving 2 cycles later -> stray_sts_o=1, no extra done.
REQ-038 linkup=0 with req_valid_i=1 -> req_ready_o=0, cmd_valid_o=0 indefinitely; linkup dropped during WAIT_STS -> transaction still completes.
REQ-039 rst asserted in WAIT_STS -> all outputs 0 immediately, rr_ptr=0, first grant after release goes to lowest valid index.

Source files
------------

// File: rtl/ma_dm_arbiter.sv
// ma_dm_arbiter: round-robin arbiter that serialises register-file requesters onto one datamover, one transaction at a time
module ma_dm_arbiter #(
    parameter int NUM_REQ        = 6,
    parameter int DDR4_ADDRWIDTH = 36,
    parameter int BRAM_ADDRWIDTH = 10,
    parameter int BTT_WIDTH      = 15,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ddr4_linkup_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_write_i,
    input  logic [NUM_REQ*DDR4_ADDRWIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*BRAM_ADDRWIDTH-1:0]  req_bram_addr_i,
    input  logic [NUM_REQ*BTT_WIDTH-1:0]       req_btt_i,
    output logic [NUM_REQ-1:0]                 done_o,
    output logic [NUM_REQ-1:0]                 err_o,
    output logic                               cmd_valid_o,
    input  logic                               cmd_ready_i,
    output logic                               cmd_write_o,
    output logic [DDR4_ADDRWIDTH-1:0]          cmd_addr_o,
    output logic [BRAM_ADDRWIDTH-1:0]          cmd_bram_addr_o,
    output logic [BTT_WIDTH-1:0]               cmd_btt_o,
    input  logic                               sts_valid_i,
    input  logic                               sts_ok_i,
    output logic                               sts_ready_o,
    output logic                               busy_o,
    output logic                               stray_sts_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int IW = PW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_STS = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] rr_ptr, grant, win;
    logic [IW-1:0] idx;
    logic [WW-1:0] wd;
    logic          any_valid, accept;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins last
    always_comb begin
        win = '0;
        any_valid = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + IW'(k);
            idx = (idx >= IW'(NUM_REQ)) ? idx - IW'(NUM_REQ) : idx;
            if (req_valid_i[idx[PW-1:0]]) begin
                win = idx[PW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign accept      = (state == IDLE) && ddr4_linkup_i && any_valid;
    assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
    assign cmd_valid_o = state == ISSUE;
    assign sts_ready_o = state != ISSUE;
    assign busy_o      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            wd              <= '0;
            stray_sts_o     <= 1'b0;
            done_o          <= '0;
            err_o           <= '0;
            cmd_write_o     <= 1'b0;
            cmd_addr_o      <= '0;
            cmd_bram_addr_o <= '0;
            cmd_btt_o       <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state)
                IDLE: begin
                    if (sts_valid_i) stray_sts_o <= 1'b1;
                    if (accept) begin
                        grant  <= win;
                        rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        state  <= ISSUE;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (win == PW'(i)) begin
                                cmd_write_o     <= req_write_i[i];
                                cmd_addr_o      <= req_addr_i[i*DDR4_ADDRWIDTH +: DDR4_ADDRWIDTH];
                                cmd_bram_addr_o <= req_bram_addr_i[i*BRAM_ADDRWIDTH +: BRAM_ADDRWIDTH];
                                cmd_btt_o       <= req_btt_i[i*BTT_WIDTH +: BTT_WIDTH];
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        state <= WAIT_STS;
                        wd    <= '0;
                    end
                end
                WAIT_STS: begin
                    // A real status wins over a watchdog expiry landing in the same cycle
                    if (sts_valid_i || wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        done_o <= NUM_REQ'(1) << grant;
                        err_o  <= (sts_valid_i && sts_ok_i) ? '0 : (NUM_REQ'(1) << grant);
                        state  <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ma_dm_arbiter.sv
// tb_ma_dm_arbiter: randomized scoreboard bench for ma_dm_arbiter with a queue-based requester/datamover model
module tb_ma_dm_arbiter;
    localparam int N = 6;

    logic           clk = 1'b0, rst = 1'b1, ddr4_linkup_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0, req_ready_o, req_write_i, done_o, err_o;
    logic [N*36-1:0] req_addr_i;
    logic [N*10-1:0] req_bram_addr_i;
    logic [N*15-1:0] req_btt_i;
    logic           cmd_valid_o, cmd_ready_i = 1'b0, cmd_write_o;
    logic [35:0]    cmd_addr_o;
    logic [9:0]     cmd_bram_addr_o;
    logic [14:0]    cmd_btt_o;
    logic           sts_valid_i = 1'b0, sts_ok_i = 1'b0, sts_ready_o, busy_o, stray_sts_o;

    logic           w_a [N];
    logic [35:0]    a_a [N];
    logic [9:0]     b_a [N];
    logic [14:0]    t_a [N];
    logic [N-1:0]   pend = '0;
    int             mptr = 0, cyc = 0, checks = 0, errors = 0;

    typedef struct {logic w; logic [35:0] a; logic [9:0] b; logic [14:0] t;} cmd_t;
    typedef struct {int g; logic e; int due;} done_t;
    cmd_t  cq[$];
    done_t dq[$];

    ma_dm_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .ddr4_linkup_i(ddr4_linkup_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_bram_addr_i(req_bram_addr_i), .req_btt_i(req_btt_i),
        .done_o(done_o), .err_o(err_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o),
        .cmd_addr_o(cmd_addr_o), .cmd_bram_addr_o(cmd_bram_addr_o), .cmd_btt_o(cmd_btt_o),
        .sts_valid_i(sts_valid_i), .sts_ok_i(sts_ok_i), .sts_ready_o(sts_ready_o),
        .busy_o(busy_o), .stray_sts_o(stray_sts_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_write_i[i]            = w_a[i];
            req_addr_i[i*36 +: 36]    = a_a[i];
            req_bram_addr_i[i*10 +: 10] = b_a[i];
            req_btt_i[i*15 +: 15]     = t_a[i];
        end
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    task automatic rand_fields(input int i);
        logic [63:0] r;
        r = {$urandom, $urandom};
        w_a[i] = r[63];
        a_a[i] = r[35:0];
        b_a[i] = (i < 4) ? 10'($urandom % 64) : 10'($urandom % 1024);
        t_a[i] = ($urandom % 4 == 0) ? 15'd0 : 15'($urandom % 32768);
    endtask

    // Round-robin reference: first pending index at or after the pointer, wrapping
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    // Starts at a negedge with the arbiter idle and linkup high; ends at a negedge with it idle again
    task automatic txn(input logic [N-1:0] add, input int d, input int mode, input int lat, input bit drop);
        int win, c;
        for (int i = 0; i < N; i++) if (add[i] && !pend[i]) begin pend[i] = 1'b1; rand_fields(i); end
        if (pend == '0) begin pend[0] = 1'b1; rand_fields(0); end
        req_valid_i = pend;
        win = pick(pend, mptr);
        #1;
        chk("req_ready", req_ready_o, N'(1) << win);
        cq.push_back('{w_a[win], a_a[win], b_a[win], t_a[win]});
        mptr = (win + 1) % N;
        pend[win] = 1'b0;
        @(negedge clk);
        req_valid_i = pend;
        rand_fields(win);
        #1;
        chk("busy_issue", busy_o, 1);
        chk("ready_busy", req_ready_o, 0);
        repeat (d) @(negedge clk);
        cmd_ready_i = 1'b1;
        c = cyc;
        @(negedge clk);
        cmd_ready_i = 1'b0;
        if (mode == 2) begin
            ddr4_linkup_i = 1'b0;
            dq.push_back('{win, 1'b1, c + 9});
            while (cyc < c + 9) @(negedge clk);
            if (pend == '0) begin pend[1] = 1'b1; rand_fields(1); end
            req_valid_i = pend;
            repeat (2) begin
                #1;
                chk("ready_linkdown", req_ready_o, 0);
                chk("cmd_linkdown", cmd_valid_o, 0);
                @(negedge clk);
            end
            sts_valid_i = 1'b1;
            sts_ok_i = 1'($urandom);
            @(negedge clk);
            sts_valid_i = 1'b0;
            #1;
            chk("stray_sts", stray_sts_o, 1);
            @(negedge clk);
            ddr4_linkup_i = 1'b1;
        end else begin
            if (drop) ddr4_linkup_i = 1'b0;
            repeat (lat) @(negedge clk);
            sts_valid_i = 1'b1;
            sts_ok_i = (mode == 0);
            dq.push_back('{win, mode == 1, cyc + 1});
            @(negedge clk);
            sts_valid_i = 1'b0;
            if (drop) begin
                #1;
                chk("ready_linkdown_done", req_ready_o, 0);
                @(negedge clk);
                ddr4_linkup_i = 1'b1;
            end
        end
    endtask

    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && cmd_valid_o) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: cmd_valid_o=1 expected no command at cycle %0d", cyc);
                end else begin
                    chk("cmd_write", cmd_write_o, cq[0].w);
                    chk("cmd_addr", cmd_addr_o, cq[0].a);
                    chk("cmd_bram", cmd_bram_addr_o, cq[0].b);
                    chk("cmd_btt", cmd_btt_o, cq[0].t);
                    if (cmd_ready_i) void'(cq.pop_front());
                end
            end
            if (done_o != '0) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done_o=%0h expected 0 at cycle %0d", done_o, cyc);
                end else begin
                    e = dq.pop_front();
                    chk("done", done_o, N'(1) << e.g);
                    chk("err", err_o, e.e ? (N'(1) << e.g) : N'(0));
                    chk("done_cycle", cyc, e.due);
                end
            end else begin
                chk("err_nodone", err_o, 0);
                if (dq.size() > 0 && cyc > dq[0].due) begin
                    checks++;
                    errors++;
                    $display("FAIL done_missing: no done_o for grant %0d expected at cycle %0d", dq[0].g, dq[0].due);
                    void'(dq.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) rand_fields(i);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_cmd_valid", cmd_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_stray", stray_sts_o, 0);
        chk("rst_sts_ready", sts_ready_o, 1);
        chk("rst_cmd_addr", cmd_addr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        pend = '1;
        req_valid_i = pend;
        repeat (4) begin
            #1;
            chk("linkdown_ready", req_ready_o, 0);
            chk("linkdown_cmd", cmd_valid_o, 0);
            @(negedge clk);
        end
        ddr4_linkup_i = 1'b1;
        repeat (6) txn('0, 0, 0, 3, 1'b0);
        txn(6'h01, 0, 0, 3, 1'b0);
        txn(6'h04, 1, 1, 2, 1'b0);
        pend[4] = 1'b1;
        w_a[4] = 1'b1;
        a_a[4] = 36'h1_0000_0040;
        b_a[4] = 10'h3FF;
        t_a[4] = 15'd128;
        txn('0, 5, 0, 1, 1'b0);
        txn(6'h08, 0, 2, 0, 1'b1);
        for (int n = 0; n < 150; n++)
            txn(N'($urandom), $urandom % 4, ($urandom % 6 == 0) ? 2 : int'($urandom % 2), $urandom % 6, $urandom % 4 == 0);
        pend = 6'b000100;
        req_valid_i = pend;
        cq.push_back('{w_a[2], a_a[2], b_a[2], t_a[2]});
        pend = '0;
        @(negedge clk);
        req_valid_i = pend;
        cmd_ready_i = 1'b1;
        @(negedge clk);
        cmd_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_cmd_valid", cmd_valid_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_stray", stray_sts_o, 0);
        chk("mid_rst_sts_ready", sts_ready_o, 1);
        chk("mid_rst_btt", cmd_btt_o, 0);
        dq.delete();
        cq.delete();
        mptr = 0;
        @(negedge clk);
        rst = 1'b0;
        pend = 6'b100100;
        txn('0, 0, 0, 1, 1'b0);
        txn('0, 2, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("cmd_queue_empty", cq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
